// File: rtl/alu_pkg.sv
// Shared opcodes, FSM states and flag bit positions for the multi-cycle ALU.
package alu_pkg;

    localparam logic [7:0] OP_ADD = 8'd1;
    localparam logic [7:0] OP_SUB = 8'd2;
    localparam logic [7:0] OP_MUL = 8'd3;
    localparam logic [7:0] OP_DIV = 8'd4;
    localparam logic [7:0] OP_XOR = 8'd5;
    localparam logic [7:0] OP_AND = 8'd6;
    localparam logic [7:0] OP_OR  = 8'd7;
    localparam logic [7:0] OP_REM = 8'd8;
    localparam logic [7:0] OP_NOT = 8'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    function automatic logic is_div(input logic [7:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/alu_divider.sv
// Iterative restoring unsigned divider, one quotient bit per cycle.
// o_quotient/o_remainder show the values after the current step.
module alu_divider #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH:0]   w_sh;
    logic             w_ge;

    // Dividend bits shift out of r_quo into the partial remainder.
    assign w_sh        = {r_rem, r_quo[WIDTH-1]};
    assign w_ge        = w_sh >= {1'b0, r_div};
    assign o_remainder = w_ge ? (w_sh[WIDTH-1:0] - r_div) : w_sh[WIDTH-1:0];
    assign o_quotient  = {r_quo[WIDTH-2:0], w_ge};
    assign o_busy      = r_cnt != '0;
    assign o_done      = r_cnt == CNT_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
            r_quo <= '0;
            r_rem <= '0;
            r_div <= '0;
        end else if (i_start) begin
            r_cnt <= CNT_W'(WIDTH);
            r_quo <= i_dividend;
            r_rem <= '0;
            r_div <= i_divisor;
        end else if (o_busy) begin
            r_cnt <= r_cnt - CNT_W'(1);
            r_quo <= o_quotient;
            r_rem <= o_remainder;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle execute ALU with valid/ready on both sides.
// Define ALU_FLAGS_EN to add the registered out_flags port.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_opcode,
    input  logic             in_signed,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef ALU_FLAGS_EN
    output logic [3:0]       out_flags,
`endif
    output logic [WIDTH-1:0] out_result
);

    localparam int MSB = WIDTH - 1;

    state_e           r_state;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_dz;
    logic             r_is_rem;

    logic             w_xfer;
    logic             w_is_div;
    logic             w_div_busy;
    logic             w_div_done;
    logic [WIDTH-1:0] w_add;
    logic [WIDTH-1:0] w_sub;
    logic [WIDTH-1:0] w_res;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH-1:0] w_quo;
    logic [WIDTH-1:0] w_rem;
    logic [WIDTH-1:0] w_div_res;

    assign in_ready = !w_div_busy &&
                      ((r_state == IDLE) ||
                       ((r_state == DONE) && out_ready));
    assign w_xfer   = in_valid && in_ready;
    assign w_is_div = is_div(in_opcode);

    assign w_a_mag  = (in_signed && in_a[MSB]) ? -in_a : in_a;
    assign w_b_mag  = (in_signed && in_b[MSB]) ? -in_b : in_b;
    assign w_add    = in_a + in_b;
    assign w_sub    = in_a - in_b;

    always_comb begin
        w_res = in_a;
        case (in_opcode)
            OP_ADD:  w_res = w_add;
            OP_SUB:  w_res = w_sub;
            OP_MUL:  w_res = in_a * in_b;
            OP_XOR:  w_res = in_a ^ in_b;
            OP_AND:  w_res = in_a & in_b;
            OP_OR:   w_res = in_a | in_b;
            OP_NOT:  w_res = ~in_a;
            default: w_res = in_a;
        endcase
    end

    alu_divider #(
        .WIDTH(WIDTH)
    ) u_div (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_start    (w_xfer && w_is_div),
        .i_dividend (w_a_mag),
        .i_divisor  (w_b_mag),
        .o_busy     (w_div_busy),
        .o_done     (w_div_done),
        .o_quotient (w_quo),
        .o_remainder(w_rem)
    );

    // Divide by zero forces an all-ones quotient regardless of sign.
    always_comb begin
        if (r_is_rem)
            w_div_res = r_neg_r ? -w_rem : w_rem;
        else if (r_dz)
            w_div_res = '1;
        else
            w_div_res = r_neg_q ? -w_quo : w_quo;
    end

`ifdef ALU_FLAGS_EN
    logic [3:0] r_flags;
    logic [3:0] w_flags;

    assign out_flags = r_flags;

    always_comb begin
        w_flags         = '0;
        w_flags[FLAG_Z] = w_res == '0;
        w_flags[FLAG_N] = w_res[MSB];
        if (in_opcode == OP_ADD) begin
            w_flags[FLAG_C] = w_add < in_a;
            w_flags[FLAG_V] = (in_a[MSB] == in_b[MSB]) &&
                              (w_add[MSB] != in_a[MSB]);
        end else if (in_opcode == OP_SUB) begin
            w_flags[FLAG_C] = in_a < in_b;
            w_flags[FLAG_V] = (in_a[MSB] != in_b[MSB]) &&
                              (w_sub[MSB] != in_a[MSB]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_flags <= '0;
        else if (w_xfer && !w_is_div)
            r_flags <= w_flags;
        else if (r_state == BUSY && w_div_done)
            r_flags <= '0;
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            out_valid  <= 1'b0;
            out_result <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_dz       <= 1'b0;
            r_is_rem   <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_xfer && w_is_div) begin
                        r_state   <= BUSY;
                        out_valid <= 1'b0;
                        r_neg_q   <= in_signed && (in_a[MSB] ^ in_b[MSB]);
                        r_neg_r   <= in_signed && in_a[MSB];
                        r_dz      <= in_b == '0;
                        r_is_rem  <= in_opcode == OP_REM;
                    end else if (w_xfer) begin
                        r_state    <= DONE;
                        out_valid  <= 1'b1;
                        out_result <= w_res;
                    end else if (r_state == DONE && out_ready) begin
                        r_state   <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                BUSY: begin
                    if (w_div_done) begin
                        r_state    <= DONE;
                        out_valid  <= 1'b1;
                        out_result <= w_div_res;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised multi-cycle successor of the single-cycle execute ALU.
- Same opcode set, widened to WIDTH bits, with a valid/ready handshake on both sides.
- Signed or unsigned DIV/REM through an iterative restoring divider; all other ops return in one cycle.
- Sits in the execute stage between the issue register and the writeback register. Only one operation is in flight at a time.

Parameters:
- WIDTH, 64, operand and result width in bits (>=8, even).
- CNT_W, $clog2(WIDTH+1), width of the divider iteration counter (derived; do not override).

Ports:
- clk  in  1  clock, all state changes on posedge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request this cycle.
- in_opcode  in  8  operation code (package constants).
- in_signed  in  1  DIV/REM treat operands as two's complement; ignored for other ops.
- in_a  in  WIDTH  operand 1.
- in_b  in  WIDTH  operand 2.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_result  out  WIDTH  result.
- out_flags  out  4  {overflow, carry, negative, zero}; present only with ALU_FLAGS_EN.

Behaviour:
- Reset (async, reset_n=0): state=IDLE, out_valid=0, out_result=0, out_flags=0, counter=0. in_ready=1 after release.
- States:
  - IDLE: in_ready=1.
    - Transfer (in_valid && in_ready) with op not DIV/REM: compute and register out_result, go to DONE.
    - Transfer with DIV/REM: latch magnitudes, result signs and op, load counter=WIDTH, go to BUSY.
  - BUSY: in_ready=0. One restoring quotient bit per cycle, counter decrements. At counter==1, write corrected quotient/remainder to out_result, go to DONE.
  - DONE: out_valid=1, out_result held stable. in_ready=out_ready.
    - out_ready=1 and a new transfer in the same cycle: result drains and the new op starts (behaves as from IDLE). This gives back-to-back one-cycle throughput.
    - out_ready=1 and no transfer: go to IDLE.
- Latency, from the acceptance edge to out_valid high:
  - single-cycle ops: 1 cycle.
  - DIV/REM: WIDTH+1 cycles.
- Ops:
  - ADD=1, SUB=2: modulo 2^WIDTH.
  - MUL=3: low WIDTH bits of the product, single cycle.
  - DIV=4, REM=8: divider.
  - XOR=5, AND=6, OR=7: bitwise.
  - NOT=9: ~in_a.
  - Any other code: out_result=in_a.
- Divide by zero (in_b==0): still takes WIDTH+1 cycles. DIV gives all ones; REM gives in_a.
- Signed overflow (in_a=most negative, in_b=-1): DIV gives in_a, REM gives 0.
- Signed divide: quotient negative iff operand signs differ. Remainder takes the sign of in_a.
- Inputs are sampled only on the transfer edge; later changes on in_* are ignored.
- reset_n asserted mid-BUSY or mid-DONE: the operation is abandoned and no result is produced.

Optional Feature:
- Macro ALU_FLAGS_EN.
- When defined:
  - out_flags is registered alongside out_result.
  - zero = (out_result==0); negative = out_result[WIDTH-1].
  - carry = carry-out for ADD, borrow for SUB, else 0.
  - overflow = signed overflow for ADD/SUB, else 0.
  - flags=0 for DIV/REM.
- When undefined: the out_flags port and all flag logic are absent.

Decomposition:
- Package alu_pkg:
  - opcode localparams (ADD..NOT, same values as the existing ALU);
  - state enum typedef {IDLE, BUSY, DONE};
  - flag bit index constants.
- One sub-module, alu_divider. It is a restoring unsigned divider with start/busy/done handshake, parameterised by WIDTH. Sign correction stays in alu_mc.

Test Plan:
- WIDTH=64: ADD in_a=0xFFFF_FFFF_FFFF_FFFF, in_b=1 -> out_valid one cycle later, result 0. With ALU_FLAGS_EN, flags zero=1, carry=1.
- Back-to-back SUB 10-3 then MUL 6*7 with out_ready held at 1 -> results 7 and 42 on consecutive cycles, in_ready never drops.
- DIV unsigned 100/7 -> out_valid exactly 65 cycles after acceptance, result 14. REM same operands -> result 2.
- Signed DIV -7/2 -> 0xFFFF_FFFF_FFFF_FFFD (-3). Signed REM -7/2 -> -1. Signed DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000.
- DIV 5/0 -> all ones; REM 5/0 -> 5. Hold out_ready=0 for 10 cycles -> out_result stable, in_ready=0 throughout.
- Pulse reset_n low at cycle 20 of a DIV -> out_valid=0, out_result=0 immediately. After release, ADD 2+2 -> 4 with 1-cycle latency.
